// File: rtl/limits_buffer_pkg.sv
// limits_buffer_pkg: shared widths, payload types and FSM encoding for the
// limits buffer RAM slave.
package limits_buffer_pkg;

  localparam int unsigned LB_ADDR_W = 8;
  localparam int unsigned LB_DATA_W = 32;
  localparam int unsigned LB_DEPTH  = 256;
  localparam int unsigned LB_BE_W   = LB_DATA_W / 8;

  typedef logic [LB_ADDR_W-1:0] lb_addr_t;
  typedef logic [LB_DATA_W-1:0] lb_data_t;
  typedef logic [LB_BE_W-1:0]   lb_be_t;

  typedef enum logic [0:0] {
    LB_INIT  = 1'b0,
    LB_READY = 1'b1
  } lb_ram_state_e;

endpackage

// File: rtl/limits_ram_core.sv
// limits_ram_core: true dual-port RAM with byte-enable writes and registered,
// enable-held read data (1-cycle latency). Out-of-range addresses read 0 and
// ignore writes. Read registers clear on reset; the array itself does not.
// Ports: clock/reset; per port X in {a,b}: x_wr_en, x_rd_en, x_addr,
//        x_wdata, x_be in; x_rdata out.
module limits_ram_core
  import limits_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = LB_DEPTH,
  parameter int unsigned ADDR_W = LB_ADDR_W,
  parameter int unsigned DATA_W = LB_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_wr_en,
  input  logic                  a_rd_en,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [DATA_W/8-1:0]   a_be,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_wr_en,
  input  logic                  b_rd_en,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  input  logic [DATA_W/8-1:0]   b_be,
  output logic [DATA_W-1:0]     b_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              a_in_rng, b_in_rng;
  logic [IDX_W-1:0]  a_idx, b_idx;

  assign a_in_rng = 32'(a_addr) < DEPTH;
  assign b_in_rng = 32'(b_addr) < DEPTH;
  assign a_idx    = a_addr[IDX_W-1:0];
  assign b_idx    = b_addr[IDX_W-1:0];

  // Array write; port A is applied last so it wins a same-address clash.
  always_ff @(posedge clock) begin
    for (int i = 0; i < BE_W; i++) begin
      if (b_wr_en && b_in_rng && b_be[i]) mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
      if (a_wr_en && a_in_rng && a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  // Read registers load only on a read and otherwise hold (read-before-write).
  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_rd_en) a_rdata_d = a_in_rng ? mem[a_idx] : '0;
    if (b_rd_en) b_rdata_d = b_in_rng ? mem[b_idx] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/limits_buffer_ram.sv
// limits_buffer_ram: Avalon-MM dual-port slave holding the limits buffer.
// After reset the array is cleared one word per cycle (init_done then rises);
// port A always has priority, port B stalls on same-address collisions that
// involve a write. Read latency is one cycle; readdata holds between reads.
// Ports: clock, reset (sync, active-high); avs_a_* / avs_b_* Avalon-MM slave
//        ports (address, chipselect, read, readdata, write, writedata,
//        byteenable, waitrequest); init_done.
// Build option: LIMITS_RAM_RDW_BYPASS_EN forwards a port A write to a
//        colliding port B read instead of stalling B.
module limits_buffer_ram
  import limits_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = LB_DEPTH,
  parameter int unsigned ADDR_W = LB_ADDR_W,
  parameter int unsigned DATA_W = LB_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   avs_a_address,
  input  logic                avs_a_chipselect,
  input  logic                avs_a_read,
  output logic [DATA_W-1:0]   avs_a_readdata,
  input  logic                avs_a_write,
  input  logic [DATA_W-1:0]   avs_a_writedata,
  input  logic [DATA_W/8-1:0] avs_a_byteenable,
  output logic                avs_a_waitrequest,
  input  logic [ADDR_W-1:0]   avs_b_address,
  input  logic                avs_b_chipselect,
  input  logic                avs_b_read,
  output logic [DATA_W-1:0]   avs_b_readdata,
  input  logic                avs_b_write,
  input  logic [DATA_W-1:0]   avs_b_writedata,
  input  logic [DATA_W/8-1:0] avs_b_byteenable,
  output logic                avs_b_waitrequest,
  output logic                init_done
);

  localparam int unsigned BE_W = DATA_W / 8;

  lb_ram_state_e     state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;

  logic a_wr, a_rd, a_req, b_wr, b_rd, b_req, same_addr, ready, collide;

  logic              core_a_wr, core_a_rd, core_b_wr, core_b_rd;
  logic [ADDR_W-1:0] core_a_addr;
  logic [DATA_W-1:0] core_a_wdata, core_a_rdata, core_b_rdata;
  logic [BE_W-1:0]   core_a_be;

  // Request decode; read+write together is treated as a write.
  assign a_wr      = avs_a_chipselect & avs_a_write;
  assign a_rd      = avs_a_chipselect & avs_a_read & ~avs_a_write;
  assign a_req     = a_wr | a_rd;
  assign b_wr      = avs_b_chipselect & avs_b_write;
  assign b_rd      = avs_b_chipselect & avs_b_read & ~avs_b_write;
  assign b_req     = b_wr | b_rd;
  assign same_addr = avs_a_address == avs_b_address;
  assign ready     = (state_q == LB_READY) & ~reset;

`ifdef LIMITS_RAM_RDW_BYPASS_EN
  // A-write/B-read is forwarded; only a B write can still clash.
  assign collide = a_req & b_wr & same_addr;
`else
  assign collide = a_req & b_req & same_addr & (a_wr | b_wr);
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LB_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Next state: sweep every word once, then serve users.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      LB_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(DEPTH - 1)) state_d = LB_READY;
      end
      LB_READY: state_d = LB_READY;
      default:  state_d = LB_INIT;
    endcase
    init_done_d = state_d == LB_READY;
  end

  // Outputs: stalls and RAM port control; INIT owns port A for clearing.
  always_comb begin
    avs_a_waitrequest = ~ready;
    avs_b_waitrequest = ~ready | collide;
    core_a_wr    = 1'b0;
    core_a_rd    = 1'b0;
    core_a_addr  = avs_a_address;
    core_a_wdata = avs_a_writedata;
    core_a_be    = avs_a_byteenable;
    core_b_wr    = ready & b_wr & ~collide;
    core_b_rd    = ready & b_rd & ~collide;
    if (state_q == LB_INIT) begin
      core_a_wr    = 1'b1;
      core_a_addr  = init_cnt_q;
      core_a_wdata = '0;
      core_a_be    = '1;
    end else begin
      core_a_wr = ready & a_wr;
      core_a_rd = ready & a_rd;
    end
  end

  limits_ram_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clock   (clock),
    .reset   (reset),
    .a_wr_en (core_a_wr),
    .a_rd_en (core_a_rd),
    .a_addr  (core_a_addr),
    .a_wdata (core_a_wdata),
    .a_be    (core_a_be),
    .a_rdata (core_a_rdata),
    .b_wr_en (core_b_wr),
    .b_rd_en (core_b_rd),
    .b_addr  (avs_b_address),
    .b_wdata (avs_b_writedata),
    .b_be    (avs_b_byteenable),
    .b_rdata (core_b_rdata)
  );

  assign avs_a_readdata = core_a_rdata;
  assign init_done      = init_done_q;

`ifdef LIMITS_RAM_RDW_BYPASS_EN
  logic              byp_q, byp_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic [BE_W-1:0]   byp_be_q, byp_be_d;

  // Capture the colliding A write alongside the B read; held like readdata.
  always_comb begin
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    byp_be_d   = byp_be_q;
    if (core_b_rd) begin
      byp_d      = core_a_wr & same_addr & (32'(avs_b_address) < DEPTH);
      byp_data_d = avs_a_writedata;
      byp_be_d   = avs_a_byteenable;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      byp_be_q   <= '0;
    end else begin
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      byp_be_q   <= byp_be_d;
    end
  end

  // Core returned the old word; overlay the freshly written bytes.
  always_comb begin
    avs_b_readdata = core_b_rdata;
    for (int i = 0; i < BE_W; i++) begin
      if (byp_q && byp_be_q[i]) avs_b_readdata[8*i +: 8] = byp_data_q[8*i +: 8];
    end
  end
`else
  assign avs_b_readdata = core_b_rdata;
`endif

  a_rw_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(avs_a_chipselect && avs_a_read && avs_a_write))
    else $error("port A read and write asserted together");
  b_rw_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(avs_b_chipselect && avs_b_read && avs_b_write))
    else $error("port B read and write asserted together");

endmodule

// File: tb/tb_limits_buffer_ram.sv
// Testbench for limits_buffer_ram: random and directed Avalon traffic on both
// ports, checked against a word-array reference model with a readdata
// scoreboard. Follows LIMITS_RAM_RDW_BYPASS_EN when defined.
module tb_limits_buffer_ram;
  import limits_buffer_pkg::*;

  localparam int unsigned DEPTH = LB_DEPTH;

  typedef struct packed {
    logic     cs;
    logic     rd;
    logic     wr;
    lb_addr_t addr;
    lb_data_t data;
    lb_be_t   be;
  } txn_t;

  logic     clock = 1'b0;
  logic     reset = 1'b1;
  txn_t     ta = '0, tb = '0;
  lb_data_t avs_a_readdata, avs_b_readdata;
  logic     avs_a_waitrequest, avs_b_waitrequest, init_done;

  int checks = 0;
  int failures = 0;

  limits_buffer_ram dut (
    .clock             (clock),
    .reset             (reset),
    .avs_a_address     (ta.addr),
    .avs_a_chipselect  (ta.cs),
    .avs_a_read        (ta.rd),
    .avs_a_readdata    (avs_a_readdata),
    .avs_a_write       (ta.wr),
    .avs_a_writedata   (ta.data),
    .avs_a_byteenable  (ta.be),
    .avs_a_waitrequest (avs_a_waitrequest),
    .avs_b_address     (tb.addr),
    .avs_b_chipselect  (tb.cs),
    .avs_b_read        (tb.rd),
    .avs_b_readdata    (avs_b_readdata),
    .avs_b_write       (tb.wr),
    .avs_b_writedata   (tb.data),
    .avs_b_byteenable  (tb.be),
    .avs_b_waitrequest (avs_b_waitrequest),
    .init_done         (init_done)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  lb_data_t    mem_m [DEPTH];
  lb_data_t    q_a[$], q_b[$];
  lb_data_t    last_a = '0, last_b = '0;
  bit          ready_m = 1'b0;
  int unsigned init_m = 0;

  function automatic lb_data_t merge(input lb_data_t old, input lb_data_t nw, input lb_be_t be);
    lb_data_t r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic lb_data_t rd_model(input lb_addr_t a);
    return (32'(a) < DEPTH) ? mem_m[a] : '0;
  endfunction

  always @(negedge clock) begin
    bit ra, wa, rb, wb, conflict, exp_wa, exp_wb;
    // Outputs produced by the edge just past.
    if (q_a.size() != 0) last_a = q_a.pop_front();
    if (q_b.size() != 0) last_b = q_b.pop_front();
    chk("readdata_a", avs_a_readdata, last_a);
    chk("readdata_b", avs_b_readdata, last_b);
    chk("init_done", 32'(init_done), 32'(ready_m));

    // This cycle's requests.
    wa = ta.cs && ta.wr;
    ra = ta.cs && ta.rd && !ta.wr;
    wb = tb.cs && tb.wr;
    rb = tb.cs && tb.rd && !tb.wr;
    conflict = (wa || ra) && (wb || rb) && (ta.addr == tb.addr) && (wa || wb);
`ifdef LIMITS_RAM_RDW_BYPASS_EN
    if (wa && rb) conflict = 1'b0;
`endif
    exp_wa = reset || !ready_m;
    exp_wb = exp_wa || conflict;
    chk("waitrequest_a", 32'(avs_a_waitrequest), 32'(exp_wa));
    chk("waitrequest_b", 32'(avs_b_waitrequest), 32'(exp_wb));

    if (reset) begin
      q_a.delete();
      q_b.delete();
      last_a  = '0;
      last_b  = '0;
      ready_m = 1'b0;
      init_m  = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (!ready_m) begin
      init_m++;
      if (init_m == DEPTH) ready_m = 1'b1;
    end else begin
      // Writes land before reads: same-address write/read only completes
      // together when the new data is forwarded.
      if (wa && 32'(ta.addr) < DEPTH) mem_m[ta.addr] = merge(mem_m[ta.addr], ta.data, ta.be);
      if (wb && !exp_wb && 32'(tb.addr) < DEPTH) mem_m[tb.addr] = merge(mem_m[tb.addr], tb.data, tb.be);
      if (ra) q_a.push_back(rd_model(ta.addr));
      if (rb && !exp_wb) q_b.push_back(rd_model(tb.addr));
    end
  end

  // ---------------- stimulus ----------------
  function automatic txn_t mk(input bit rd, input bit wr, input int unsigned addr,
                              input lb_data_t data, input lb_be_t be);
    txn_t t;
    t.cs   = rd | wr;
    t.rd   = rd;
    t.wr   = wr;
    t.addr = LB_ADDR_W'(addr);
    t.data = data;
    t.be   = be;
    return t;
  endfunction

  // One transfer on each port; B is held (A idle) while it is stalled.
  task automatic step(input txn_t a, input txn_t b, output int stalls);
    stalls = 0;
    ta = a;
    tb = b;
    @(negedge clock);
    while (avs_b_waitrequest && b.cs && !reset) begin
      stalls++;
      if (stalls > 16) begin
        checks++;
        failures++;
        $display("FAIL b_stall_bound: port B still stalled after %0d cycles", stalls);
        break;
      end
      @(posedge clock);
      #1 ta = '0;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    ta = '0;
    tb = '0;
  endtask

  initial begin
    int st, total;
    txn_t ra_t, rb_t;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (DEPTH) @(posedge clock);
    #1;

    // Cleared array.
    step(mk(1, 0, 0, '0, '0), mk(1, 0, 255, '0, '0), st);
    chk("init_zero_a0", avs_a_readdata, 32'h0);
    chk("init_zero_b255", avs_b_readdata, 32'h0);
    step(mk(1, 0, 128, '0, '0), '0, st);
    chk("init_zero_a128", avs_a_readdata, 32'h0);

    // Simple write then read back on B.
    step(mk(0, 1, 5, 32'hDEADBEEF, 4'hF), '0, st);
    step('0, '0, st);
    step('0, mk(1, 0, 5, '0, '0), st);
    chk("b_read5_stalls", 32'(st), 32'd0);
    chk("b_read5", avs_b_readdata, 32'hDEADBEEF);

    // Partial byte-enable overwrite.
    step(mk(0, 1, 7, 32'h11223344, 4'hF), '0, st);
    step(mk(0, 1, 7, 32'hAABBCCDD, 4'h3), '0, st);
    step('0, mk(1, 0, 7, '0, '0), st);
    chk("b_read7_merge", avs_b_readdata, 32'h1122CCDD);

    // Same-cycle A write / B read collision.
    step(mk(0, 1, 9, 32'h00000055, 4'hF), mk(1, 0, 9, '0, '0), st);
`ifdef LIMITS_RAM_RDW_BYPASS_EN
    chk("collide9_stalls", 32'(st), 32'd0);
`else
    chk("collide9_stalls", 32'(st), 32'd1);
`endif
    chk("collide9_data", avs_b_readdata, 32'h00000055);

    // Streaming: B trails A by one address, then wrap to 0.
    total = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rb_t = (i > 0) ? mk(1, 0, i - 1, '0, '0) : txn_t'('0);
      step(mk(0, 1, i, $urandom, 4'hF), rb_t, st);
      total += st;
    end
    step(mk(0, 1, 0, $urandom, 4'hF), mk(1, 0, 255, '0, '0), st);
    total += st;
    step('0, mk(1, 0, 0, '0, '0), st);
    chk("stream_stalls", 32'(total), 32'd0);

    // Random mixed traffic on a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      int unsigned opa = $urandom_range(0, 3);
      int unsigned opb = $urandom_range(0, 3);
      int unsigned lim = ($urandom_range(0, 3) == 0) ? 255 : 3;
      ra_t = mk(opa == 1 || opa == 3, opa == 2, $urandom_range(0, lim), $urandom, lb_be_t'($urandom));
      rb_t = mk(opb == 1 || opb == 3, opb == 2, $urandom_range(0, lim), $urandom, lb_be_t'($urandom));
      step(ra_t, rb_t, st);
    end

    // Reset in the middle of a stream, at the write to address 100.
    for (int i = 95; i <= 100; i++) begin
      if (i == 100) reset = 1'b1;
      step(mk(0, 1, i, 32'hA5A50000 | 32'(i), 4'hF), mk(1, 0, i - 1, '0, '0), st);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (DEPTH) @(posedge clock);
    #1;
    step(mk(1, 0, 100, '0, '0), mk(1, 0, 99, '0, '0), st);
    chk("reinit_a100", avs_a_readdata, 32'h0);
    chk("reinit_b99", avs_b_readdata, 32'h0);
    step('0, '0, st);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/limits_buffer_ram.md
Name: limits_buffer_ram

Overview:
Avalon-MM dual-port slave that implements the limits buffer storage. It responds to the buffer controller's port A (write side, fed by the level generator) and port B (read side, feeding the hard limiter). It provides:
- a byte-enabled RAM array with fixed read latency;
- post-reset zero-initialisation;
- waitrequest generation for initialisation and same-address port collisions.

Parameters:
DEPTH, 256, number of 32-bit words; must be a power of two, at most 2**ADDR_W.
ADDR_W, 8, word-address width.
DATA_W, 32, data width; must be a multiple of 8.

Ports:
clock  in  1  clock
reset  in  1  reset; synchronous, active-high
avs_a_address  in  ADDR_W  port A word address
avs_a_chipselect  in  1  port A select
avs_a_read  in  1  port A read request
avs_a_readdata  out  DATA_W  port A read data
avs_a_write  in  1  port A write request
avs_a_writedata  in  DATA_W  port A write data
avs_a_byteenable  in  DATA_W/8  port A byte lanes
avs_a_waitrequest  out  1  port A stall
avs_b_address  in  ADDR_W  port B word address
avs_b_chipselect  in  1  port B select
avs_b_read  in  1  port B read request
avs_b_readdata  out  DATA_W  port B read data
avs_b_write  in  1  port B write request
avs_b_writedata  in  DATA_W  port B write data
avs_b_byteenable  in  DATA_W/8  port B byte lanes
avs_b_waitrequest  out  1  port B stall
init_done  out  1  high once the array is cleared

Behaviour:
- Interface: reset is reset (synchronous, active-high); clock is clock; all state updates on posedge clock.
- Reset values: readdata_a/b = 0, init_done = 0, FSM = INIT, init counter = 0. waitrequest_a/b read 1 during reset and INIT.
- FSM states: INIT, READY.
  - INIT: writes 0 to address init_cnt every cycle and increments init_cnt.
  - At init_cnt == DEPTH-1 the FSM moves to READY. init_done rises DEPTH cycles after reset deasserts.
  - In INIT both waitrequests are 1 regardless of requests; no user access is performed.
- Request definition: a port request is chipselect & (read | write). read & write together on one port is illegal; treat it as a write and flag a sim assertion.
- Accepted access: a request with waitrequest = 0 in the same cycle.
- Waitrequest timing: combinational from the current cycle's inputs and FSM state.
- Write: accepted write updates only the bytes whose byteenable bit is 1. Addresses at or above DEPTH are ignored for writes.
- Read latency = 1:
  - An accepted read at cycle N presents data on readdata at N+1.
  - readdata holds its value until the next accepted read.
  - Addresses at or above DEPTH return 0.
  - byteenable is ignored on reads.
- Port A priority: avs_a_waitrequest = 0 in READY, always.
- Collision (READY): port A request and port B request to the same address, with at least one of them a write.
  - avs_b_waitrequest = 1 for that cycle; port A completes.
  - B retries each cycle and proceeds once the conflict clears.
  - Read/read to the same address: no stall.
- Masters hold address/data/controls while waitrequest is high; no internal request buffering.
- Reset mid-operation: in-flight reads are discarded (readdata -> 0). FSM returns to INIT and the array is fully re-cleared.
- chipselect = 0: read/write are ignored; waitrequest follows the FSM only.

Optional Feature:
Macro LIMITS_RAM_RDW_BYPASS_EN.
- Defined: a port A write colliding with a port B read does not stall B. B's readdata at N+1 is the byteenable-merged new word: written bytes from writedata_a, other bytes from old contents.
- Defined: write/write and B-write/A-read collisions still stall B.
- Undefined: all collisions stall B as described above.

Decomposition:
- Package limits_buffer_pkg holds:
  - LB_ADDR_W = 8, LB_DATA_W = 32, LB_DEPTH = 256;
  - typedef lb_addr_t, lb_data_t, lb_be_t;
  - enum lb_ram_state_e {LB_INIT, LB_READY}.
- Sub-module limits_ram_core: inferable true dual-port RAM with registered outputs and byte-enable writes, instantiated once. Collision logic, bypass merge and the init FSM stay in the top module.

Test Plan:
- Reset, idle 256 cycles: waitrequest_a/b = 1 through cycle 255; init_done = 1 at cycle 256; reading addresses 0, 128, 255 returns 0x00000000.
- A writes 0xDEADBEEF to addr 5 (byteenable 0xF), then B reads addr 5 two cycles later: B waitrequest = 0; readdata_b = 0xDEADBEEF the cycle after.
- A writes 0x11223344 to addr 7, then writes 0xAABBCCDD with byteenable 0x3; B reads addr 7: 0x1122CCDD.
- Same-cycle A write 0x55 / B read at addr 9 (bypass off): B waitrequest = 1 for one cycle. Next cycle the read is accepted and readdata_b = 0x55. With LIMITS_RAM_RDW_BYPASS_EN: no stall; readdata_b = 0x55 at N+1.
- Streaming: A writes addresses 0..254 while B reads 0..254 trailing by 1: no stalls; every read returns its written value; writes to address 255 and wrap back to address 0 complete.
- Reset asserted mid-stream at a write to addr 100: readdata resets to 0 and waitrequests return to 1. After re-init, addr 100 reads 0.
